// File: rtl/biriscv_trace_arb_pkg.sv
// Shared trace-entry layout and defaults for the retire-trace arbiter.
// Optional macro BIRISCV_TRACE_ARB_SEQ_EN adds a 32-bit sequence number to each entry.
package biriscv_trace_arb_pkg;

    localparam int TRACE_DEPTH_DEF = 8;
    localparam int TRACE_DROP_W_DEF = 16;

`ifdef BIRISCV_TRACE_ARB_SEQ_EN
    localparam int TRACE_ENTRY_W = 96;
`else
    localparam int TRACE_ENTRY_W = 64;
`endif

    typedef struct packed {
`ifdef BIRISCV_TRACE_ARB_SEQ_EN
        logic [31:0] seq;
`endif
        logic [31:0] pc;
        logic [31:0] opcode;
    } trace_entry_t;

    // Number of set bits in a 2-bit valid vector, as a push/drop count.
    function automatic logic [1:0] count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/biriscv_trace_fifo.sv
// 2-write/1-read circular buffer of trace entries with occupancy output.
// Latency: written entry visible at the head the cycle after the write edge.
// Backpressure: none internally; caller must never push more than the free space.
module biriscv_trace_fifo
    import biriscv_trace_arb_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [1:0]    push_cnt,
    input  trace_entry_t  wr_a,
    input  trace_entry_t  wr_b,
    input  logic          pop,
    output trace_entry_t  head,
    output logic [AW:0]   level
);

    trace_entry_t mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  wptr_p1;

    assign wptr_p1 = wptr + (AW+1)'(1);

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_cnt != 2'd0) begin
            mem[wptr[AW-1:0]] <= wr_a;
        end
        if (push_cnt == 2'd2) begin
            mem[wptr_p1[AW-1:0]] <= wr_b;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(push_cnt);
            rptr <= rptr + (AW+1)'(pop);
        end
    end

    assign level = wptr - rptr;
    assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/biriscv_trace_arb.sv
// Retire-trace arbiter: merges two commit pipes in program order into one trace stream.
// Latency: commit sampled at edge N is at the head after edge N (no empty bypass).
// Backpressure: stall_o when fewer than 2 slots free; excess commits are dropped and counted.
// Optional macro BIRISCV_TRACE_ARB_SEQ_EN adds per-entry sequence numbers and the seq_o port.
module biriscv_trace_arb
    import biriscv_trace_arb_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH_DEF,
    parameter int DROP_W = TRACE_DROP_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     p0_valid_i,
    input  logic [31:0]              p0_pc_i,
    input  logic [31:0]              p0_opcode_i,
    input  logic                     p1_valid_i,
    input  logic [31:0]              p1_pc_i,
    input  logic [31:0]              p1_opcode_i,
    output logic                     valid_o,
    output logic [31:0]              pc_o,
    output logic [31:0]              opcode_o,
    input  logic                     ready_i,
    output logic                     stall_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_count_o,
    input  logic                     clear_i
`ifdef BIRISCV_TRACE_ARB_SEQ_EN
    ,
    output logic [31:0]              seq_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic         v0;
    logic         v1;
    logic [LW-1:0] level;
    logic [LW-1:0] free;
    logic [1:0]   push_cnt;
    logic [1:0]   drops;
    logic         pop;
    trace_entry_t wr_a;
    trace_entry_t wr_b;
    trace_entry_t head;

    logic               overflow_q;
    logic [DROP_W-1:0]  drop_q;
    logic [DROP_W-1:0]  drop_base;
    logic [DROP_W:0]    drop_sum;

    assign v0   = enable_i & p0_valid_i;
    assign v1   = enable_i & p1_valid_i;
    assign free = LW'(DEPTH) - level;
    assign pop  = valid_o & ready_i;

`ifdef BIRISCV_TRACE_ARB_SEQ_EN
    logic [31:0] seq_q;
`endif

    // Entry A is the oldest valid commit; entry B is only ever p1 behind a valid p0.
    always_comb begin
        push_cnt    = 2'd0;
        drops       = 2'd0;
        wr_a        = '0;
        wr_b        = '0;
        wr_a.pc     = v0 ? p0_pc_i : p1_pc_i;
        wr_a.opcode = v0 ? p0_opcode_i : p1_opcode_i;
        wr_b.pc     = p1_pc_i;
        wr_b.opcode = p1_opcode_i;
`ifdef BIRISCV_TRACE_ARB_SEQ_EN
        wr_a.seq    = seq_q;
        wr_b.seq    = seq_q + 32'd1;
`endif
        case ({v0, v1})
            2'b11: begin
                if (free >= LW'(2)) begin
                    push_cnt = 2'd2;
                end else if (free == LW'(1)) begin
                    push_cnt = 2'd1;
                    drops    = 2'd1;
                end else begin
                    drops    = 2'd2;
                end
            end
            2'b10, 2'b01: begin
                if (free != '0) begin
                    push_cnt = 2'd1;
                end else begin
                    drops    = 2'd1;
                end
            end
            default: begin
                push_cnt = 2'd0;
                drops    = 2'd0;
            end
        endcase
    end

    biriscv_trace_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_cnt (push_cnt),
        .wr_a     (wr_a),
        .wr_b     (wr_b),
        .pop      (pop),
        .head     (head),
        .level    (level)
    );

    // Clear takes effect before this cycle's drops are accumulated.
    assign drop_base = clear_i ? '0 : drop_q;
    assign drop_sum  = {1'b0, drop_base} + (DROP_W+1)'(drops);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            overflow_q <= (overflow_q & ~clear_i) | (drops != 2'd0);
            drop_q     <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end

`ifdef BIRISCV_TRACE_ARB_SEQ_EN
    // Counts every enabled commit, dropped or not, so gaps in seq_o expose drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_q + 32'(count2(v0, v1));
        end
    end

    assign seq_o = valid_o ? head.seq : 32'd0;
`endif

    assign valid_o      = (level != '0);
    assign pc_o         = valid_o ? head.pc : 32'd0;
    assign opcode_o     = valid_o ? head.opcode : 32'd0;
    assign stall_o      = (free < LW'(2));
    assign level_o      = level;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_biriscv_trace_arb.sv
// Directed bench for biriscv_trace_arb (DEPTH 8, DROP_W 16); seq checks only with BIRISCV_TRACE_ARB_SEQ_EN.
module tb_biriscv_trace_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        p0_valid, p1_valid;
    logic [31:0] p0_pc, p0_opcode, p1_pc, p1_opcode;
    logic        valid;
    logic [31:0] pc, opcode;
    logic        ready;
    logic        stall;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] drop_count;
    logic        clear;
`ifdef BIRISCV_TRACE_ARB_SEQ_EN
    logic [31:0] seq;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    biriscv_trace_arb #(.DEPTH(8), .DROP_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .p0_valid_i   (p0_valid),
        .p0_pc_i      (p0_pc),
        .p0_opcode_i  (p0_opcode),
        .p1_valid_i   (p1_valid),
        .p1_pc_i      (p1_pc),
        .p1_opcode_i  (p1_opcode),
        .valid_o      (valid),
        .pc_o         (pc),
        .opcode_o     (opcode),
        .ready_i      (ready),
        .stall_o      (stall),
        .level_o      (level),
        .overflow_o   (overflow),
        .drop_count_o (drop_count),
        .clear_i      (clear)
`ifdef BIRISCV_TRACE_ARB_SEQ_EN
        ,
        .seq_o        (seq)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] pc0, input logic v1, input logic [31:0] pc1);
        p0_valid  = v0;
        p0_pc     = pc0;
        p0_opcode = pc0 ^ 32'h0000_0013;
        p1_valid  = v1;
        p1_pc     = pc1;
        p1_opcode = pc1 ^ 32'h0000_0013;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; ready = 1'b0; clear = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drops", 64'(drop_count), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single stream, consumer always ready.
        ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 1'b0, 32'h0);
        tick();
        chk("s1_valid", 64'(valid), 64'd1);
        chk("s1_pc", 64'(pc), 64'h8000_0000);
        chk("s1_op", 64'(opcode), 64'h8000_0013);
        drive(1'b1, 32'h8000_0004, 1'b0, 32'h0);
        tick();
        chk("s2_pc", 64'(pc), 64'h8000_0004);
        chk("s2_level", 64'(level), 64'd1);
        drive(1'b1, 32'h8000_0008, 1'b0, 32'h0);
        tick();
        chk("s3_pc", 64'(pc), 64'h8000_0008);
        chk("s3_stall", 64'(stall), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("s_empty_valid", 64'(valid), 64'd0);
        chk("s_empty_pc", 64'(pc), 64'd0);

        // Dual commit: p0 then p1 on consecutive cycles.
        p0_valid = 1'b1; p0_pc = 32'h100; p0_opcode = 32'h0000_0013;
        p1_valid = 1'b1; p1_pc = 32'h104; p1_opcode = 32'h00a0_0093;
        tick();
        chk("d_level", 64'(level), 64'd2);
        chk("d0_pc", 64'(pc), 64'h100);
        chk("d0_op", 64'(opcode), 64'h13);
`ifdef BIRISCV_TRACE_ARB_SEQ_EN
        chk("d0_seq", 64'(seq), 64'd3);
`endif
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("d1_pc", 64'(pc), 64'h104);
        chk("d1_op", 64'(opcode), 64'h00a0_0093);
`ifdef BIRISCV_TRACE_ARB_SEQ_EN
        chk("d1_seq", 64'(seq), 64'd4);
`endif
        tick();
        chk("d_drained", 64'(level), 64'd0);

        // p1 alone becomes a single entry.
        ready = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 32'h150);
        tick();
        chk("p1only_level", 64'(level), 64'd1);
        chk("p1only_pc", 64'(pc), 64'h150);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        ready = 1'b1;
        tick();
        chk("p1only_drained", 64'(level), 64'd0);

        // Fill with the consumer stalled.
        ready = 1'b0;
        drive(1'b1, 32'h200, 1'b1, 32'h204);
        tick();
        chk("f_lvl2", 64'(level), 64'd2);
        drive(1'b1, 32'h208, 1'b1, 32'h20c);
        tick();
        chk("f_lvl4", 64'(level), 64'd4);
        drive(1'b1, 32'h210, 1'b1, 32'h214);
        tick();
        chk("f_lvl6", 64'(level), 64'd6);
        chk("f_stall6", 64'(stall), 64'd0);
        drive(1'b1, 32'h218, 1'b0, 32'h0);
        tick();
        chk("f_lvl7", 64'(level), 64'd7);
        chk("f_stall7", 64'(stall), 64'd1);
        drive(1'b1, 32'h21c, 1'b1, 32'h220);
        tick();
        chk("f_lvl8", 64'(level), 64'd8);
        chk("f_drop1", 64'(drop_count), 64'd1);
        chk("f_ovf", 64'(overflow), 64'd1);
        chk("f_head", 64'(pc), 64'h200);

        // Full with pop: both commits dropped, pop still happens.
        ready = 1'b1;
        drive(1'b1, 32'h224, 1'b1, 32'h228);
        tick();
        chk("fp_level", 64'(level), 64'd7);
        chk("fp_drops", 64'(drop_count), 64'd3);
        chk("fp_head", 64'(pc), 64'h204);

        // Build drop count to 5, then clear in a dropping cycle.
        ready = 1'b0;
        drive(1'b1, 32'h22c, 1'b1, 32'h230);
        tick();
        chk("c_drop4", 64'(drop_count), 64'd4);
        chk("c_lvl8", 64'(level), 64'd8);
        drive(1'b1, 32'h234, 1'b0, 32'h0);
        tick();
        chk("c_drop5", 64'(drop_count), 64'd5);
        clear = 1'b1;
        drive(1'b1, 32'h238, 1'b0, 32'h0);
        tick();
        chk("c_collide_cnt", 64'(drop_count), 64'd1);
        chk("c_collide_ovf", 64'(overflow), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("c_clear_cnt", 64'(drop_count), 64'd0);
        chk("c_clear_ovf", 64'(overflow), 64'd0);
        clear = 1'b0;

        // Disabled commits neither push nor drop.
        enable = 1'b0;
        drive(1'b1, 32'h240, 1'b1, 32'h244);
        tick();
        chk("en_drops", 64'(drop_count), 64'd0);
        chk("en_ovf", 64'(overflow), 64'd0);
        chk("en_level", 64'(level), 64'd8);
        enable = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0);

        // Drain three, then reset with five entries held.
        ready = 1'b1;
        tick(); tick(); tick();
        chk("r_level5", 64'(level), 64'd5);
        chk("r_head", 64'(pc), 64'h210);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive(1'b1, 32'h0, 1'b1, 32'h0);
        enable = 1'b0;
        tick();
        chk("r_level3", 64'(level), 64'd3);
        enable = 1'b1;
        drive(1'b1, 32'h260, 1'b1, 32'h264);
        ready = 1'b0;
        tick();
        chk("r_level5b", 64'(level), 64'd5);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("r_async_valid", 64'(valid), 64'd0);
        chk("r_async_level", 64'(level), 64'd0);
        chk("r_async_drops", 64'(drop_count), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 32'h300, 1'b0, 32'h0);
        tick();
        chk("r_first_pc", 64'(pc), 64'h300);
        chk("r_first_level", 64'(level), 64'd1);
`ifdef BIRISCV_TRACE_ARB_SEQ_EN
        chk("r_first_seq", 64'(seq), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
